// File: rtl/uart_pkg.sv
// uart_pkg: shared register map, STATUS bit positions and TX state type for bus_uart_tx.
//   Register offsets : REG_TXDATA, REG_STATUS, REG_DIVLO, REG_DIVHI (address[1:0])
//   STATUS bits      : ST_BUSY, ST_FULL, ST_EMPTY, ST_OVF
//   tx_state_t       : IDLE, START, DATA, STOP
package uart_pkg;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIVLO  = 2'd2;
    localparam logic [1:0] REG_DIVHI  = 2'd3;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // A programmed divisor of zero still yields one-cycle bits.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/bus_uart_tx_fifo.sv
// byte_fifo: synchronous byte FIFO; a push while full is accepted when a pop happens on the same edge.
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din    : write request and data
//   pop, dout    : read request and head-of-queue data (valid while !empty)
//   full, empty  : occupancy flags
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push, do_pop;

    always_comb begin
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        empty   = wr_q == rd_q;
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d    = wr_q + {{AW{1'b0}}, do_push};
        rd_d    = rd_q + {{AW{1'b0}}, do_pop};
        dout    = mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // When full with a simultaneous pop, the slot written is the one being read
    // out this cycle; dout is consumed before the edge overwrites it.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: memory-mapped 8N1 UART transmitter responding on the CPU memory bus.
//   clk, reset_n         : clock, asynchronous active-low reset
//   address, data_write  : CPU bus address and write data
//   read_write           : 1 = write, 0 = read
//   data_read, sel       : registered read data and read-mux select, one cycle after the access
//   tx                   : serial output, idle high
//   irq_n                : low while the FIFO is empty and the transmitter is idle
module bus_uart_tx
    import uart_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'hD000,
    parameter logic [15:0] DEFAULT_DIV = 16'd434,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] address,
    input  logic [7:0]  data_write,
    input  logic        read_write,
    output logic [7:0]  data_read,
    output logic        sel,
    output logic        tx,
    output logic        irq_n
);

    logic        hit, wr, rd, push, pop, last;
    logic [1:0]  off;
    logic        full, empty;
    logic [7:0]  fifo_dout, status, rdata;

    tx_state_t   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] bdiv_q, bdiv_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [15:0] div_q, div_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  dr_q, dr_d;
    logic        sel_q, sel_d;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (data_write),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        hit  = address[15:2] == BASE[15:2];
        off  = address[1:0];
        wr   = hit && read_write;
        rd   = hit && !read_write;
        push = wr && off == REG_TXDATA;
        state_d = state_q;
        cnt_d   = cnt_q;
        bdiv_d  = bdiv_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        // bdiv_q latches the divisor at each bit boundary so a divisor write
        // never stretches or shortens the bit already on the line.
        last = cnt_q == bdiv_q - 16'd1;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = START;
                    cnt_d   = '0;
                    bdiv_d  = eff_div(div_q);
                end
            end
            START: begin
                if (last) begin
                    state_d = DATA;
                    idx_d   = '0;
                    cnt_d   = '0;
                    bdiv_d  = eff_div(div_q);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (last) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = '0;
                    bdiv_d  = eff_div(div_q);
                    state_d = (idx_q == 3'd7) ? STOP : DATA;
                    idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (last) begin
                    cnt_d  = '0;
                    bdiv_d = eff_div(div_q);
                    if (!empty) begin
                        // Back-to-back frame: no idle bit between STOP and START.
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // tx is registered from the next state so the line changes on the same
        // edge as the state, giving one cycle from TXDATA write to start bit.
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
        div_d = {(wr && off == REG_DIVHI) ? data_write : div_q[15:8],
                 (wr && off == REG_DIVLO) ? data_write : div_q[7:0]};
        // A dropped push only happens when full and the FSM is not popping.
        ovf_d = (rd && off == REG_STATUS) ? 1'b0 : (push && full && !pop) ? 1'b1 : ovf_q;
        status           = 8'h00;
        status[ST_BUSY]  = state_q != IDLE;
        status[ST_FULL]  = full;
        status[ST_EMPTY] = empty;
        status[ST_OVF]   = ovf_q;
        rdata = (off == REG_STATUS) ? status :
                (off == REG_DIVLO)  ? div_q[7:0] :
                (off == REG_DIVHI)  ? div_q[15:8] : 8'h00;
        dr_d  = rd ? rdata : 8'h00;
        sel_d = rd;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bdiv_q  <= 16'd1;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            div_q   <= DEFAULT_DIV;
            ovf_q   <= 1'b0;
            dr_q    <= 8'h00;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bdiv_q  <= bdiv_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
            dr_q    <= dr_d;
            sel_q   <= sel_d;
        end
    end

    assign data_read = dr_q;
    assign sel       = sel_q;
    assign tx        = tx_q;
    assign irq_n     = !(state_q == IDLE && empty);

endmodule

// File: tb/tb_bus_uart_tx.sv
// tb_bus_uart_tx: randomized self-checking bench for bus_uart_tx with a queue-based waveform model.
module tb_bus_uart_tx;

    localparam logic [15:0] BASE  = 16'hD000;
    localparam logic [15:0] DEF   = 16'd434;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] address = 16'h0000;
    logic [7:0]  data_write = 8'h00;
    logic        read_write = 1'b0;
    logic [7:0]  data_read;
    logic        sel, tx, irq_n;

    bus_uart_tx #(.BASE(BASE), .DEFAULT_DIV(DEF), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .data_write (data_write),
        .read_write (read_write),
        .data_read  (data_read),
        .sel        (sel),
        .tx         (tx),
        .irq_n      (irq_n)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: queued bytes, and the future tx line levels one entry per cycle.
    logic [7:0]  fq[$];
    bit          wave[$];
    bit          cur, in_frame, m_ovf, exp_sel;
    logic [7:0]  exp_dr;
    logic [15:0] m_div;

    function automatic void check(string name, logic [15:0] act, logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic void model_reset();
        fq.delete();
        wave.delete();
        cur = 1'b1;
        in_frame = 1'b0;
        m_ovf = 1'b0;
        m_div = DEF;
        exp_sel = 1'b0;
        exp_dr = 8'h00;
    endfunction

    function automatic bit model_idle();
        return fq.size() == 0 && wave.size() == 0 && !in_frame;
    endfunction

    function automatic void model_step();
        bit hit, pop_now, accept, lv;
        logic [1:0] off;
        logic [15:0] pd;
        logic [7:0] b;
        hit = (address >> 2) == (BASE >> 2);
        off = address[1:0];
        pop_now = wave.size() == 0 && fq.size() > 0;
        accept = fq.size() < DEPTH || pop_now;
        pd = (m_div == 16'd0) ? 16'd1 : m_div;
        exp_sel = hit && !read_write;
        exp_dr = 8'h00;
        if (exp_sel) begin
            if (off == 2'd1) exp_dr = {4'b0, m_ovf, fq.size() == 0, fq.size() == DEPTH, in_frame};
            if (off == 2'd2) exp_dr = m_div[7:0];
            if (off == 2'd3) exp_dr = m_div[15:8];
            if (off == 2'd1) m_ovf = 1'b0;
        end
        if (pop_now) begin
            b = fq.pop_front();
            for (int k = 0; k < 10; k++) begin
                lv = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
                repeat (pd) wave.push_back(lv);
            end
        end
        if (hit && read_write) begin
            if (off == 2'd0) begin
                if (accept) fq.push_back(data_write);
                else m_ovf = 1'b1;
            end
            if (off == 2'd2) m_div[7:0] = data_write;
            if (off == 2'd3) m_div[15:8] = data_write;
        end
        if (wave.size() > 0) begin
            cur = wave.pop_front();
            in_frame = 1'b1;
        end else begin
            cur = 1'b1;
            in_frame = 1'b0;
        end
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset_n) model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en && reset_n) begin
            check("tx", tx, cur);
            check("irq_n", irq_n, !(fq.size() == 0 && !in_frame));
            check("sel", sel, exp_sel);
            check("data_read", data_read, exp_dr);
        end
    end

    task automatic idle();
        address = 16'h0000;
        read_write = 1'b0;
        data_write = 8'h00;
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [7:0] d);
        address = a;
        read_write = 1'b1;
        data_write = d;
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] d);
        bus_wr(BASE + {14'b0, off}, d);
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] v, output logic s);
        address = a;
        read_write = 1'b0;
        @(negedge clk);
        v = data_read;
        s = sel;
        idle();
    endtask

    task automatic wait_irq(input int budget, output int took);
        took = 0;
        while (irq_n !== 1'b0 && took < budget) begin
            @(negedge clk);
            took++;
        end
        if (irq_n !== 1'b0) begin
            n_chk++;
            $display("FAIL irq_timeout: irq_n=%b after %0d cycles, required 0", irq_n, budget);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        logic s;
        logic [9:0] got;
        int took, c0, r;
        logic [15:0] a;
        model_reset();
        idle();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk_en = 1'b1;
        check("reset_tx", tx, 1);
        check("reset_irq_n", irq_n, 0);
        check("reset_sel", sel, 0);
        rd(BASE + 16'd1, v, s);
        check("reset_status_sel", s, 1);
        check("reset_status", v, 8'h04);

        wr(2'd2, 8'h04);
        wr(2'd3, 8'h00);
        rd(BASE + 16'd2, v, s);
        check("divlo_readback", v, 8'h04);
        wr(2'd0, 8'hA5);
        check("tx_before_start", tx, 1);
        @(negedge clk);
        check("tx_start_latency", tx, 0);
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 2) got[i/4] = tx;
            if (i == 39) check("irq_n_in_stop", irq_n, 1);
            @(negedge clk);
        end
        check("frame_bits_a5", got, 10'b1101001010);
        check("tx_after_frame", tx, 1);
        check("irq_n_after_frame", irq_n, 0);

        wr(2'd0, 8'h01);
        c0 = cyc;
        for (int i = 2; i <= 5; i++) wr(2'd0, 8'(i));
        rd(BASE + 16'd1, v, s);
        check("status_full", v, 8'h03);
        wr(2'd0, 8'h06);
        rd(BASE + 16'd1, v, s);
        check("status_overflow", v, 8'h0B);
        rd(BASE + 16'd1, v, s);
        check("status_ovf_cleared", v, 8'h03);
        wait_irq(400, took);
        check("five_frames_cycles", 16'(cyc - c0), 16'd201);

        wr(2'd2, 8'h00);
        wr(2'd3, 8'h00);
        rd(BASE + 16'd2, v, s);
        check("divlo_zero", v, 8'h00);
        wr(2'd0, 8'h3C);
        wait_irq(100, took);
        check("div0_frame_cycles", 16'(took), 16'd11);

        rd(BASE + 16'd4, v, s);
        check("outside_sel", s, 0);
        check("outside_data", v, 8'h00);
        rd(16'h0001, v, s);
        check("ram_sel", s, 0);
        bus_wr(BASE + 16'd4, 8'h77);
        @(negedge clk);
        check("outside_write_irq_n", irq_n, 0);
        rd(BASE + 16'd1, v, s);
        check("outside_write_status", v, 8'h04);

        wr(2'd2, 8'(1 + $urandom_range(0, 2)));
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) wr(2'd0, 8'($urandom_range(0, 255)));
            else if (r <= 5) rd(BASE + 16'd1, v, s);
            else if (r == 6) rd(BASE + 16'($urandom_range(0, 3)), v, s);
            else if (r == 7 || r == 8) begin
                a = 16'($urandom_range(0, 65535));
                if ((a >> 2) == (BASE >> 2)) a = 16'h1234;
                if (r == 7) bus_wr(a, 8'($urandom_range(0, 255)));
                else rd(a, v, s);
            end else if (model_idle()) wr(2'd2, 8'($urandom_range(0, 3)));
            else @(negedge clk);
        end
        wait_irq(3000, took);

        wr(2'd2, 8'h04);
        wr(2'd3, 8'h00);
        wr(2'd0, 8'h00);
        repeat (10) @(negedge clk);
        check("tx_mid_data", tx, 0);
        chk_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("tx_async_reset", tx, 1);
        check("irq_n_async_reset", irq_n, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        chk_en = 1'b1;
        rd(BASE + 16'd1, v, s);
        check("status_after_reset", v, 8'h04);
        rd(BASE + 16'd2, v, s);
        check("divlo_default", v, 8'hB2);
        rd(BASE + 16'd3, v, s);
        check("divhi_default", v, 8'h01);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_uart_tx.md
Name: bus_uart_tx

Overview:
- Memory-mapped UART transmitter acting as a responder on the CPU memory bus (address, data_write, read_write, data_read), alongside the RAM.
- The CPU writes bytes into a small TX FIFO and polls a status register.
- A bit-timing state machine serialises FIFO bytes onto tx as 8N1 frames, LSB first.

Parameters:
- BASE, 16'hD000, base address; 4-byte window, BASE[1:0] must be 0.
- DEFAULT_DIV, 16'd434, reset value of the baud divisor, in clk cycles per bit.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  16  CPU bus address.
- data_write  in  8  CPU write data.
- read_write  in  1  1 = write, 0 = read (same encoding as the RAM wren).
- data_read  out  8  registered read data, valid the cycle after the access.
- sel  out  1  registered; 1 when data_read carries this block's data (top-level read mux select).
- tx  out  1  serial output, idle high.
- irq_n  out  1  active low while the FIFO is empty and the FSM is idle (transmit complete).

Behaviour:
- Reset values (asynchronous, on reset_n low):
  - data_read = 8'h00, sel = 0, tx = 1, irq_n = 0.
  - FIFO emptied, FSM = IDLE, divisor = DEFAULT_DIV, overflow = 0.
- Decode: hit = (address[15:2] == BASE[15:2]). Offset = address[1:0]. Evaluated every cycle; there is no enable strobe.
- Register map:
  - +0 TXDATA (W): push data_write into the FIFO. Reads return 8'h00.
  - +1 STATUS (R): bit0 busy (FSM != IDLE), bit1 full, bit2 empty, bit3 overflow, bits7:4 = 0. Writes are ignored.
  - +2 DIVLO (R/W): divisor[7:0].
  - +3 DIVHI (R/W): divisor[15:8].
- Read timing: one-cycle latency, matching the synchronous RAM.
  - Cycle N: hit with read_write = 0 → cycle N+1: sel = 1, data_read = register value sampled at N.
  - Non-hit or write cycle → next cycle: sel = 0, data_read = 8'h00.
- STATUS read: clears overflow at the same edge that captures it, so the captured value shows 1 once.
- Push rules:
  - Accepted if not full, or if full with a simultaneous FSM pop.
  - Otherwise the byte is dropped and overflow is set.
- Divisor:
  - Effective divisor = max(divisor, 1).
  - DIVLO and DIVHI writes take effect at the next bit boundary; the bit in progress keeps its length.
- FSM states: IDLE, START, DATA, STOP.
  - A bit counter counts 0..div-1 per bit; a bit index counts 0..7 in DATA.
  - IDLE: tx = 1. If the FIFO is non-empty, pop into the shift register and go to START on the next edge.
  - START: tx = 0 for div cycles, then go to DATA.
  - DATA: tx = shift[0]; after div cycles shift right; after the 8th bit go to STOP.
  - STOP: tx = 1 for div cycles. Then, if the FIFO is non-empty, pop and go straight to START (back-to-back frames, no idle gap); else go to IDLE.
  - Frame length = 10·div cycles. Latency from the accepted TXDATA write edge to the tx falling edge = 1 cycle when idle.
- tx is driven from a flop (glitch-free).
- FIFO pointers: log2(FIFO_DEPTH)+1 bits wide, wrapping. Full when the MSBs differ and the rest are equal; empty when all bits are equal.
- Reset mid-frame: tx returns high immediately; the partial frame and FIFO contents are lost.
- Accesses outside the window have no effect on internal state.

Decomposition:
- Shared package uart_pkg:
  - Register offsets REG_TXDATA, REG_STATUS, REG_DIVLO, REG_DIVHI.
  - STATUS bit positions.
  - FSM state typedef tx_state_t (IDLE, START, DATA, STOP).
- Sub-module byte_fifo:
  - Parameter DEPTH.
  - Ports: push, din, pop, dout, full, empty.
  - Synchronous FIFO with simultaneous push/pop when full.
- The top level holds the bus decode, registers and TX FSM.

Test Plan:
- Reset, then read STATUS at BASE+1 → next cycle sel = 1, data_read = 8'h04; tx = 1; irq_n = 0.
- Write divisor 4 (DIVLO = 8'h04, DIVHI = 8'h00), then write 8'hA5 to BASE → tx falls 1 cycle later; bit-sampling at cycle centres gives 0,1,0,1,0,0,1,0,1,1; frame = 40 cycles; irq_n returns low after STOP.
- With div = 4, write 5 bytes (8'h01..8'h05) back-to-back → the first is popped immediately, the remaining 4 fill the FIFO; STATUS reads bit1 = 1 and bit3 = 0. A 6th write → STATUS = 8'h0B (busy, full, overflow), and a second STATUS read shows bit3 = 0. tx emits 01..05 consecutively with no idle gaps, for 200 cycles total.
- Write DIVLO = 8'h00, DIVHI = 8'h00 → bits last 1 cycle; frame = 10 cycles. Read DIVLO → 8'h00.
- Assert reset_n low mid-DATA-bit → tx = 1 within the same cycle (asynchronous); STATUS afterwards = 8'h04; divisor reads back DEFAULT_DIV.
- Read address BASE+4 and RAM addresses → sel = 0, data_read = 8'h00; a write to BASE+4 does not change the FIFO.
